// File: rtl/poliriscv_pkg.sv
// Shared definitions for the instruction-memory boot loader: frame field
// widths, the default frame start marker and the loader state encoding.
package poliriscv_pkg;

    localparam int LEN_W = 16;   // frame length field, in 32-bit words
    localparam int CHK_W = 8;    // frame checksum field (XOR of data bytes)

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs a stream of bytes little-endian into 32-bit words. The lane a byte
// lands in is byte_idx; word_valid pulses for one cycle after lane 3 fills,
// with the completed word on the word output in that same cycle.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        strobe,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        last_lane
);

    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;

    // Next-state: clear restarts at lane 0, a strobe writes the current lane.
    always_comb begin
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear) begin
            byte_idx_d = 2'd0;
        end else if (strobe) begin
            case (byte_idx_q)
                2'd0:    word_d[7:0]   = byte_in;
                2'd1:    word_d[15:8]  = byte_in;
                2'd2:    word_d[23:16] = byte_in;
                default: word_d[31:24] = byte_in;
            endcase
            byte_idx_d   = byte_idx_q + 2'd1;
            word_valid_d = (byte_idx_q == 2'd3);
        end
    end

    // Packer registers; reset drops any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_q   <= 2'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign last_lane  = (byte_idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses framed bytes (SYNC, LEN_LO, LEN_HI, LEN*4 data,
// CHK), writes packed words into instruction memory and holds the core in
// reset until a frame has loaded with a matching checksum.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready;
// in_ready is registered and only depends on reset, never on in_valid.
module imem_loader
    import poliriscv_pkg::*;
#(
    parameter int         instructions = 256,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         AW           = $clog2(instructions)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          core_rst,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   words_loaded,
    output loader_state_e dbg_state
);

    loader_state_e    state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CHK_W-1:0] chk_q, chk_d;
    logic [AW:0]      word_cnt_q, word_cnt_d;
    logic [AW:0]      words_loaded_q, words_loaded_d;
    logic [AW-1:0]    imem_addr_q, imem_addr_d;
    logic             in_ready_q, in_ready_d;
    logic             load_done_q, load_done_d;
    logic             load_err_q, load_err_d;
    logic             core_rst_q, core_rst_d;

    logic             accept;
    logic             is_sync;
    logic             start_frame;
    logic             last_lane;
    logic [LEN_W-1:0] len_full;

    assign accept   = in_valid && in_ready_q;
    assign is_sync  = (in_data == SYNC_BYTE);
    assign len_full = {in_data, len_q[7:0]};
    assign start_frame = accept && is_sync &&
                         ((state_q == ST_SYNC) || (state_q == ST_DONE) || (state_q == ST_ERROR));

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (in_data),
        .strobe     (accept && (state_q == ST_DATA)),
        .clear      (start_frame),
        .word       (imem_wdata),
        .word_valid (imem_we),
        .last_lane  (last_lane)
    );

    // Frame parser next-state; every transition is gated by byte acceptance.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        chk_d          = chk_q;
        word_cnt_d     = word_cnt_q;
        words_loaded_d = words_loaded_q;
        imem_addr_d    = imem_addr_q;
        in_ready_d     = 1'b1;
        load_done_d    = load_done_q;
        load_err_d     = load_err_q;
        // The core leaves reset one edge after load_done rises.
        core_rst_d     = ~load_done_q;
        if (accept) begin
            case (state_q)
                ST_SYNC, ST_DONE, ST_ERROR: begin
                    if (is_sync) begin
                        state_d        = ST_LEN_LO;
                        chk_d          = '0;
                        word_cnt_d     = '0;
                        words_loaded_d = '0;
                        load_done_d    = 1'b0;
                        load_err_d     = 1'b0;
                        core_rst_d     = 1'b1;
                    end
                end
                ST_LEN_LO: begin
                    len_d[7:0] = in_data;
                    state_d    = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    len_d = len_full;
                    if (len_full > LEN_W'(instructions)) begin
                        state_d    = ST_ERROR;
                        load_err_d = 1'b1;
                    end else if (len_full == '0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    chk_d = chk_q ^ in_data;
                    if (last_lane) begin
                        imem_addr_d    = word_cnt_q[AW-1:0];
                        word_cnt_d     = word_cnt_q + 1'b1;
                        words_loaded_d = word_cnt_q + 1'b1;
                        if ((LEN_W'(word_cnt_q) + 1'b1) == len_q) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (in_data == chk_q) begin
                        state_d     = ST_DONE;
                        load_done_d = 1'b1;
                    end else begin
                        state_d    = ST_ERROR;
                        load_err_d = 1'b1;
                    end
                end
                default: state_d = ST_SYNC;
            endcase
        end
    end

    // Loader state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_SYNC;
            len_q          <= '0;
            chk_q          <= '0;
            word_cnt_q     <= '0;
            words_loaded_q <= '0;
            imem_addr_q    <= '0;
            in_ready_q     <= 1'b0;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
            core_rst_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            chk_q          <= chk_d;
            word_cnt_q     <= word_cnt_d;
            words_loaded_q <= words_loaded_d;
            imem_addr_q    <= imem_addr_d;
            in_ready_q     <= in_ready_d;
            load_done_q    <= load_done_d;
            load_err_q     <= load_err_d;
            core_rst_q     <= core_rst_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_addr    = imem_addr_q;
    assign core_rst     = core_rst_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_loaded_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a table of per-byte expectations for the first
// frame, then hand-written sequences for the multi-cycle corner cases.
// Every instruction-memory write is matched against an expected queue
// holding {acceptance cycle of the word's last byte, address, data}.
module tb_imem_loader;
    import poliriscv_pkg::*;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_loaded;
    loader_state_e dbg_state;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded),
        .dbg_state    (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int acc_cyc = 0;
    logic [55:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every write strobe must match the head of exp_q
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", imem_addr, imem_wdata);
            end else begin
                logic [55:0] e;
                e = exp_q.pop_front();
                check("we_cycle", 32'(cyc), 32'(e[55:40]));
                check("we_addr", 32'(imem_addr), 32'(e[39:32]));
                check("we_data", imem_wdata, e[31:0]);
            end
        end
    end

    // Driver: present a byte until it is accepted; returns #1 after that edge
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        int n;
        rdy = 1'b0;
        n = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!rdy && n < 20) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        acc_cyc = cyc;
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected 1", n);
        end
    endtask

    task automatic push_write(input logic [7:0] addr, input logic [31:0] data);
        exp_q.push_back({16'(acc_cyc), addr, data});
    endtask

    task automatic send_word(input logic [7:0] addr, input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
        push_write(addr, w);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic done, input logic err,
                                input logic cr, input logic [8:0] wl);
        check({tag, "_done"}, 32'(load_done), 32'(done));
        check({tag, "_err"}, 32'(load_err), 32'(err));
        check({tag, "_core_rst"}, 32'(core_rst), 32'(cr));
        check({tag, "_words"}, 32'(words_loaded), 32'(wl));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_SYNC));
        check_status(tag, 1'b0, 1'b0, 1'b1, 9'd0);
    endtask

    typedef struct {
        logic [7:0]  b;
        logic        push;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic        done;
        logic        err;
        logic        cr;
        logic [8:0]  wl;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Frame A5 02 00 | 13 00 00 00 | 93 00 10 00 | CHK = 13^93^10 = 90
        vecs[0]  = '{8'hA5, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 9'd0};
        vecs[1]  = '{8'h02, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 9'd0};
        vecs[2]  = '{8'h00, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 9'd0};
        vecs[3]  = '{8'h13, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 9'd0};
        vecs[4]  = '{8'h00, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 9'd0};
        vecs[5]  = '{8'h00, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 9'd0};
        vecs[6]  = '{8'h00, 1'b1, 8'h00, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 9'd1};
        vecs[7]  = '{8'h93, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 9'd1};
        vecs[8]  = '{8'h00, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 9'd1};
        vecs[9]  = '{8'h10, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 9'd1};
        vecs[10] = '{8'h00, 1'b1, 8'h01, 32'h0010_0093, 1'b0, 1'b0, 1'b1, 9'd2};
        vecs[11] = '{8'h90, 1'b0, 8'h00, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 9'd2};

        // Reset
        rst = 1'b1;
        idle(3);
        check_reset_values("reset");
        rst = 1'b0;
        idle(1);
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // Good two-word frame, byte by byte from the table
        for (int i = 0; i < 12; i++) begin
            send_byte(vecs[i].b);
            if (vecs[i].push) push_write(vecs[i].waddr, vecs[i].wdata);
            check_status($sformatf("vec%0d", i), vecs[i].done, vecs[i].err, vecs[i].cr, vecs[i].wl);
        end
        idle(1);
        check_status("good_after", 1'b1, 1'b0, 1'b0, 9'd2);
        check("good_state", 32'(dbg_state), 32'(ST_DONE));

        // Same frame with a wrong checksum: writes happen, frame rejected
        send_byte(8'hA5);
        check_status("bad_sync", 1'b0, 1'b0, 1'b1, 9'd0);
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(8'h00, 32'h0000_0013);
        send_word(8'h01, 32'h0010_0093);
        send_byte(8'h00);
        check_status("bad_chk", 1'b0, 1'b1, 1'b1, 9'd2);
        idle(2);
        check_status("bad_hold", 1'b0, 1'b1, 1'b1, 9'd2);

        // Garbage before sync, A5 as a data byte: 0x332211A5, CHK = A5^11^22^33 = A5
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        check_status("garbage", 1'b0, 1'b1, 1'b1, 9'd2);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(8'h00, 32'h3322_11A5);
        send_byte(8'hA5);
        check_status("a5data_chk", 1'b1, 1'b0, 1'b1, 9'd1);
        idle(1);
        check("a5data_core_rst", 32'(core_rst), 32'd0);

        // LEN = 257 exceeds the memory: error right after LEN_HI, no writes
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        check_status("len257", 1'b0, 1'b1, 1'b1, 9'd0);
        check("len257_state", 32'(dbg_state), 32'(ST_ERROR));
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        idle(2);
        check_status("len257_drop", 1'b0, 1'b1, 1'b1, 9'd0);

        // Reset after two data bytes of a word: no write, next frame from addr 0
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        idle(1);
        check_reset_values("midrst");
        rst = 1'b0;
        idle(2);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(8'h00, 32'h0403_0201);
        send_byte(8'h04);
        check_status("midrst_frame", 1'b1, 1'b0, 1'b1, 9'd1);
        idle(1);
        check("midrst_core_rst", 32'(core_rst), 32'd0);

        // Reload after DONE: core_rst rises after A5, falls again after CHK
        send_byte(8'hA5);
        check_status("reload_sync", 1'b0, 1'b0, 1'b1, 9'd0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(8'h00, 32'hDEAD_BEEF);
        send_byte(8'h22);
        check_status("reload_chk", 1'b1, 1'b0, 1'b1, 9'd1);
        idle(1);
        check_status("reload_after", 1'b1, 1'b0, 1'b0, 9'd1);

        idle(3);
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
